// File: rtl/kgp_pc_pkg.sv
// kgp_pc_pkg: shared definitions for the KGP_RISC program-counter sequencer.
//   - state_e    : sequencer FSM states
//   - SEL_*      : next-PC select encodings carried on nxt_sel
//   - PC_W_DEF   : default program-counter / fetch-address width
package kgp_pc_pkg;

  localparam int PC_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_REL = 2'b01;
  localparam logic [1:0] SEL_ABS = 2'b10;
  localparam logic [1:0] SEL_RET = 2'b11;

endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC selection for the sequencer.
// Ports:
//   pc       in  current program counter
//   nxt_sel  in  select (seq / relative / absolute / return)
//   offset   in  signed two's-complement branch offset, relative to pc+1
//   target   in  absolute jump/call target
//   link_reg in  saved return address
//   pc_inc   out pc+1, also the value a call saves into the link register
//   next_pc  out selected next program counter
// All arithmetic wraps modulo 2^PC_W.
module pc_next_calc
  import kgp_pc_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] pc,
  input  logic [1:0]      nxt_sel,
  input  logic [PC_W-1:0] offset,
  input  logic [PC_W-1:0] target,
  input  logic [PC_W-1:0] link_reg,
  output logic [PC_W-1:0] pc_inc,
  output logic [PC_W-1:0] next_pc
);

  // Adding the raw two's-complement offset at PC_W bits gives the signed
  // result directly once the carry out is dropped.
  always_comb begin
    pc_inc  = pc + PC_W'(1);
    next_pc = pc_inc;
    case (nxt_sel)
      SEL_SEQ: next_pc = pc_inc;
      SEL_REL: next_pc = pc_inc + offset;
      SEL_ABS: next_pc = target;
      SEL_RET: next_pc = link_reg;
      default: next_pc = pc_inc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: handshaked, haltable program-counter sequencer for KGP_RISC.
// Owns the PC and link register, requests fetches from instruction memory,
// waits for the datapath to complete each instruction and then advances the
// PC. A fetch that is not acknowledged within FETCH_TIMEOUT cycles parks the
// sequencer in a sticky fault state that only rst leaves.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   imem_req     out fetch request (high throughout FETCH)
//   imem_addr    out fetch address (= pc)
//   imem_ack     in  instruction returned
//   instr_valid  out one-cycle pulse in the first EXEC cycle
//   exec_done    in  datapath finished; next-PC inputs valid
//   nxt_sel, offset, target, link  in  next-PC controls
//   halt_req, resume  in  stop after current instruction / restart
//   pc, halted, fault out status
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_BOOT  | single settling cycle after reset, no request
// ST_FETCH | imem_req high, waiting for imem_ack, timeout counting
// ST_EXEC  | instruction handed to datapath, waiting for exec_done
// ST_HALT  | stopped at pc, waiting for resume
// ST_FAULT | fetch timed out; frozen until rst
module pc_sequencer
  import kgp_pc_pkg::*;
#(
  parameter int                PC_W          = PC_W_DEF,
  parameter logic [PC_W-1:0]   RESET_VEC     = '0,
  parameter int unsigned       FETCH_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  output logic            instr_valid,
  input  logic            exec_done,
  input  logic [1:0]      nxt_sel,
  input  logic [PC_W-1:0] offset,
  input  logic [PC_W-1:0] target,
  input  logic            link,
  input  logic            halt_req,
  input  logic            resume,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            fault
);

  // wait_cnt counts completed no-ack FETCH cycles; the fault is taken on
  // the cycle where it already holds FETCH_TIMEOUT-1 and still sees no ack.
  localparam bit TIMEOUT_EN = (FETCH_TIMEOUT != 0);
  localparam int CNT_W      = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    (FETCH_TIMEOUT > 0) ? CNT_W'(FETCH_TIMEOUT - 1) : {CNT_W{1'b0}};

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   link_q, link_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              instr_valid_q, instr_valid_d;
  logic [PC_W-1:0]   next_pc;
  logic [PC_W-1:0]   pc_inc;

  pc_next_calc #(
    .PC_W (PC_W)
  ) u_next (
    .pc       (pc_q),
    .nxt_sel  (nxt_sel),
    .offset   (offset),
    .target   (target),
    .link_reg (link_q),
    .pc_inc   (pc_inc),
    .next_pc  (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_VEC;
      link_q        <= RESET_VEC;
      wait_cnt_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      link_q        <= link_d;
      wait_cnt_q    <= wait_cnt_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    link_d        = link_q;
    wait_cnt_d    = wait_cnt_q;
    instr_valid_d = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d    = ST_FETCH;
        wait_cnt_d = '0;
      end

      ST_FETCH: begin
        // An ack on the last allowed cycle is checked first so it beats
        // the timeout.
        if (imem_ack) begin
          state_d       = ST_EXEC;
          instr_valid_d = 1'b1;
          wait_cnt_d    = '0;
        end else if (TIMEOUT_EN) begin
          if (wait_cnt_q == TO_LAST) begin
            state_d = ST_FAULT;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end

      ST_EXEC: begin
        if (exec_done) begin
          // next_pc reads the old link_q, so call+return in one cycle
          // swaps the two values.
          pc_d = next_pc;
          if (link) begin
            link_d = pc_inc;
          end
          state_d    = halt_req ? ST_HALT : ST_FETCH;
          wait_cnt_d = '0;
        end
      end

      ST_HALT: begin
        if (resume) begin
          state_d    = ST_FETCH;
          wait_cnt_d = '0;
        end
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign halted      = (state_q == ST_HALT);
  assign fault       = (state_q == ST_FAULT);
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import kgp_pc_pkg::*;

  logic       clk;
  logic       rst;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic       instr_valid;
  logic       exec_done;
  logic [1:0] nxt_sel;
  logic [7:0] offset;
  logic [7:0] target;
  logic       link;
  logic       halt_req;
  logic       resume;
  logic [7:0] pc;
  logic       halted;
  logic       fault;

  int checks;
  int failures;

  pc_sequencer #(
    .PC_W          (8),
    .RESET_VEC     (8'h10),
    .FETCH_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .nxt_sel     (nxt_sel),
    .offset      (offset),
    .target      (target),
    .link        (link),
    .halt_req    (halt_req),
    .resume      (resume),
    .pc          (pc),
    .halted      (halted),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ack;
    logic       ed;
    logic [1:0] sel;
    logic [7:0] off;
    logic [7:0] tgt;
    logic       lnk;
    logic       hr;
    logic       res;
    logic       e_req;
    logic       e_iv;
    logic [7:0] e_pc;
    logic       e_halt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic ack, logic ed, logic [1:0] sel, logic [7:0] off,
                              logic [7:0] tgt, logic lnk, logic hr, logic res,
                              logic e_req, logic e_iv, logic [7:0] e_pc, logic e_halt);
    vec_t v;
    v.ack = ack; v.ed = ed; v.sel = sel; v.off = off; v.tgt = tgt;
    v.lnk = lnk; v.hr = hr; v.res = res;
    v.e_req = e_req; v.e_iv = e_iv; v.e_pc = e_pc; v.e_halt = e_halt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    imem_ack = 0; exec_done = 0; nxt_sel = SEL_SEQ; offset = 0; target = 0;
    link = 0; halt_req = 0; resume = 0;
  endtask

  // Advance one clock and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(string tag, logic e_req, logic e_iv, logic [7:0] e_pc,
                         logic e_halt, logic e_flt);
    chk({tag, "_req"},   {31'd0, imem_req},    {31'd0, e_req});
    chk({tag, "_iv"},    {31'd0, instr_valid}, {31'd0, e_iv});
    chk({tag, "_pc"},    {24'd0, pc},          {24'd0, e_pc});
    chk({tag, "_addr"},  {24'd0, imem_addr},   {24'd0, e_pc});
    chk({tag, "_halt"},  {31'd0, halted},      {31'd0, e_halt});
    chk({tag, "_fault"}, {31'd0, fault},       {31'd0, e_flt});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    idle_inputs();

    // Main program walk: boot, wrap, relative, call/return, halt/resume.
    vq.push_back(mk(0,0,SEL_SEQ,8'h00,8'h00,0,0,0, 0,0,8'h10,0)); // BOOT
    vq.push_back(mk(1,0,SEL_SEQ,8'h00,8'h00,0,0,0, 1,0,8'h10,0)); // FETCH
    vq.push_back(mk(0,1,SEL_ABS,8'h00,8'hFF,0,0,0, 0,1,8'h10,0)); // jump FF
    vq.push_back(mk(1,0,SEL_SEQ,8'h00,8'h00,0,0,0, 1,0,8'hFF,0));
    vq.push_back(mk(0,1,SEL_SEQ,8'h00,8'h00,0,0,0, 0,1,8'hFF,0)); // FF+1 wraps
    vq.push_back(mk(1,0,SEL_SEQ,8'h00,8'h00,0,0,0, 1,0,8'h00,0));
    vq.push_back(mk(0,1,SEL_ABS,8'h00,8'h20,0,0,0, 0,1,8'h00,0));
    vq.push_back(mk(1,0,SEL_SEQ,8'h00,8'h00,0,0,0, 1,0,8'h20,0));
    vq.push_back(mk(0,1,SEL_REL,8'hF0,8'h00,0,0,0, 0,1,8'h20,0)); // 20+1-16
    vq.push_back(mk(1,0,SEL_SEQ,8'h00,8'h00,0,0,0, 1,0,8'h11,0));
    vq.push_back(mk(0,1,SEL_ABS,8'h00,8'h20,0,0,0, 0,1,8'h11,0));
    vq.push_back(mk(1,0,SEL_SEQ,8'h00,8'h00,0,0,0, 1,0,8'h20,0));
    vq.push_back(mk(0,1,SEL_REL,8'h05,8'h00,0,0,0, 0,1,8'h20,0)); // 20+1+5
    vq.push_back(mk(0,1,SEL_ABS,8'h00,8'h55,0,0,0, 1,0,8'h26,0)); // exec_done in FETCH ignored
    vq.push_back(mk(1,0,SEL_SEQ,8'h00,8'h00,0,0,0, 1,0,8'h26,0));
    vq.push_back(mk(1,0,SEL_SEQ,8'h00,8'h00,0,0,0, 0,1,8'h26,0)); // ack in EXEC ignored
    vq.push_back(mk(0,1,SEL_ABS,8'h00,8'h30,0,0,0, 0,0,8'h26,0));
    vq.push_back(mk(1,0,SEL_SEQ,8'h00,8'h00,0,0,0, 1,0,8'h30,0));
    vq.push_back(mk(0,1,SEL_ABS,8'h00,8'h80,1,0,0, 0,1,8'h30,0)); // call 80, link 31
    vq.push_back(mk(1,0,SEL_SEQ,8'h00,8'h00,0,0,0, 1,0,8'h80,0));
    vq.push_back(mk(0,1,SEL_SEQ,8'h00,8'h00,0,0,0, 0,1,8'h80,0));
    vq.push_back(mk(1,0,SEL_SEQ,8'h00,8'h00,0,0,0, 1,0,8'h81,0));
    vq.push_back(mk(0,1,SEL_RET,8'h00,8'h00,0,0,0, 0,1,8'h81,0)); // return
    vq.push_back(mk(1,0,SEL_SEQ,8'h00,8'h00,0,0,0, 1,0,8'h31,0));
    vq.push_back(mk(0,1,SEL_ABS,8'h00,8'h40,0,0,0, 0,1,8'h31,0));
    vq.push_back(mk(1,0,SEL_SEQ,8'h00,8'h00,0,1,0, 1,0,8'h40,0)); // halt_req in FETCH ignored
    vq.push_back(mk(0,1,SEL_SEQ,8'h00,8'h00,0,1,0, 0,1,8'h40,0)); // halt after this one
    vq.push_back(mk(1,0,SEL_SEQ,8'h00,8'h00,0,0,0, 0,0,8'h41,1)); // HALT, ack ignored
    vq.push_back(mk(0,0,SEL_SEQ,8'h00,8'h00,0,0,1, 0,0,8'h41,1)); // resume
    vq.push_back(mk(1,0,SEL_SEQ,8'h00,8'h00,0,0,0, 1,0,8'h41,0));
    vq.push_back(mk(0,1,SEL_RET,8'h00,8'h00,1,0,0, 0,1,8'h41,0)); // link+ret swap
    vq.push_back(mk(1,0,SEL_SEQ,8'h00,8'h00,0,0,0, 1,0,8'h31,0));
    vq.push_back(mk(0,1,SEL_RET,8'h00,8'h00,0,0,0, 0,1,8'h31,0)); // return to 42
    vq.push_back(mk(1,0,SEL_SEQ,8'h00,8'h00,0,0,0, 1,0,8'h42,0));
    vq.push_back(mk(0,0,SEL_SEQ,8'h00,8'h00,0,0,0, 0,1,8'h42,0));

    // Reset state
    @(negedge clk);
    chk_all("reset", 0, 0, 8'h10, 0, 0);
    rst = 1'b0;

    foreach (vq[i]) begin
      imem_ack = vq[i].ack; exec_done = vq[i].ed; nxt_sel = vq[i].sel;
      offset = vq[i].off; target = vq[i].tgt; link = vq[i].lnk;
      halt_req = vq[i].hr; resume = vq[i].res;
      chk_all($sformatf("row%0d", i), vq[i].e_req, vq[i].e_iv, vq[i].e_pc,
              vq[i].e_halt, 1'b0);
      step();
    end
    idle_inputs();

    // Still in EXEC at 42 with no exec_done seen yet.
    chk_all("exec_hold", 0, 0, 8'h42, 0, 0);
    exec_done = 1; nxt_sel = SEL_SEQ;
    step();
    idle_inputs();

    // Timeout: four no-ack FETCH cycles then FAULT.
    for (int k = 0; k < 4; k++) begin
      chk_all($sformatf("to_wait%0d", k), 1, 0, 8'h43, 0, 0);
      step();
    end
    chk_all("to_fault", 0, 0, 8'h43, 0, 1);
    imem_ack = 1; exec_done = 1; resume = 1; nxt_sel = SEL_ABS; target = 8'h99;
    step();
    step();
    chk_all("to_sticky", 0, 0, 8'h43, 0, 1);
    idle_inputs();

    // Asynchronous reset clears the fault without a clock edge.
    #2 rst = 1'b1;
    #1 chk_all("rst_clear", 0, 0, 8'h10, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    chk_all("boot2", 0, 0, 8'h10, 0, 0);
    step();

    // Ack on the 4th (last allowed) cycle beats the timeout.
    for (int k = 0; k < 3; k++) begin
      chk_all($sformatf("ack4_wait%0d", k), 1, 0, 8'h10, 0, 0);
      step();
    end
    imem_ack = 1;
    chk_all("ack4_last", 1, 0, 8'h10, 0, 0);
    step();
    idle_inputs();
    chk_all("ack4_exec", 0, 1, 8'h10, 0, 0);
    exec_done = 1; nxt_sel = SEL_SEQ;
    step();
    idle_inputs();

    // Counter restarts per fetch: another 3 waits + ack also succeeds.
    for (int k = 0; k < 3; k++) step();
    imem_ack = 1;
    chk_all("ack4b_last", 1, 0, 8'h11, 0, 0);
    step();
    idle_inputs();
    chk_all("ack4b_exec", 0, 1, 8'h11, 0, 0);

    // Mid-instruction reset returns to reset values immediately.
    #2 rst = 1'b1;
    #1 chk_all("rst_mid", 0, 0, 8'h10, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_all("post_rst_fetch", 1, 0, 8'h10, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle instruction sequencer for the KGP_RISC core: owns the 8-bit program counter, drives fetch requests to instruction memory, waits for the datapath to finish each instruction, and selects the next PC (sequential, relative branch, absolute jump/call, return). It sits between the instruction memory port and the execute stage and replaces a free-running PC register with a handshaked, haltable, fault-detecting controller.

## Interface
- PC_W, 8, PC and address width
- RESET_VEC, 0, PC value loaded on reset
- FETCH_TIMEOUT, 15, max cycles in FETCH without imem_ack before fault; 0 disables timeout
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request, high for every cycle in FETCH
- imem_addr  out  PC_W  fetch address, always equals pc
- imem_ack  in  1  memory has returned the instruction at imem_addr
- instr_valid  out  1  one-cycle pulse: fetched instruction is valid for the datapath
- exec_done  in  1  datapath finished current instruction; next-PC inputs valid this cycle
- nxt_sel  in  2  00 seq, 01 relative, 10 absolute, 11 return
- offset  in  PC_W  signed two's-complement branch offset (nxt_sel=01)
- target  in  PC_W  absolute target (nxt_sel=10)
- link  in  1  with exec_done, save pc+1 in link register (call)
- halt_req  in  1  stop after current instruction completes
- resume  in  1  leave HALT
- pc  out  PC_W  current program counter
- halted  out  1  high while in HALT
- fault  out  1  sticky fetch-timeout flag, cleared only by rst

## Operation
- States: BOOT, FETCH, EXEC, HALT, FAULT. Reset: state=BOOT, pc=RESET_VEC, link_reg=RESET_VEC, wait_cnt=0, all other outputs 0.
- BOOT: exactly one cycle, then FETCH.
- FETCH: imem_req=1. imem_ack → EXEC, instr_valid=1 next cycle, wait_cnt=0. No ack: wait_cnt+1; after FETCH_TIMEOUT consecutive no-ack cycles → FAULT. Ack on the final allowed cycle wins over fault.
- EXEC: wait for exec_done. On exec_done: pc ← next_pc; if link, link_reg ← pc+1; then HALT if halt_req else FETCH.
- next_pc: 00 → pc+1; 01 → pc+1+offset; 10 → target; 11 → link_reg. All arithmetic mod 2^PC_W (wrap, no flag).
- link with nxt_sel=11 in the same cycle: pc ← old link_reg, link_reg ← pc+1 (read before write).
- HALT: halted=1, pc held; resume → FETCH at current pc. halt_req outside EXEC-with-exec_done is ignored (not queued).
- FAULT: fault=1, imem_req=0, pc frozen; only rst exits.
- imem_ack outside FETCH and exec_done outside EXEC are ignored.
- rst mid-operation: immediate return to reset values regardless of state; outstanding fetch abandoned.

## Timing
- imem_req, halted, fault are Moore outputs decoded from the state register; pc, instr_valid, link_reg registered.
- Minimum instruction period 2 cycles: FETCH with same-cycle ack, then EXEC with exec_done in the instr_valid cycle.
- pc changes on the edge that samples exec_done; new imem_addr visible in the following FETCH cycle.
- First imem_req asserted in the second cycle after rst deasserts (BOOT occupies the first).
- instr_valid is exactly one cycle wide, coincident with the first EXEC cycle.

## Structure
- Package kgp_pc_pkg: state enum, nxt_sel encodings (SEL_SEQ, SEL_REL, SEL_ABS, SEL_RET), default PC_W.
- Sub-module pc_next_calc: combinational mux/adder producing next_pc from pc, nxt_sel, offset, target, link_reg.
- FSM, wait counter, pc and link registers in pc_sequencer top.

## Test plan
- Reset/boot: rst pulse, RESET_VEC=8'h10 → pc=8'h10, imem_req=0 in BOOT, 1 next cycle; instr_valid one cycle after ack.
- Sequential wrap: pc=8'hFF, nxt_sel=00, exec_done → pc=8'h00.
- Relative branch: pc=8'h20, offset=8'hF0 (-16), nxt_sel=01 → pc=8'h11; offset=8'h05 → pc=8'h26.
- Call/return: pc=8'h30, link=1, nxt_sel=10, target=8'h80 → pc=8'h80, link_reg=8'h31; later nxt_sel=11 → pc=8'h31.
- Halt/resume: halt_req with exec_done at pc=8'h40, seq → halted=1, pc=8'h41, no imem_req; resume → FETCH at 8'h41.
- Timeout: FETCH_TIMEOUT=4, no ack → fault=1 after 4th cycle, imem_req=0; ack in 4th cycle → no fault; rst clears fault.
